wrr_arbiter: RTL and testbench

//  - Weighted round-robin arbiter that shares one downstream resource (e.g. a PIFO

---
 rtl/wrr_arbiter_pkg.sv | 10 +
 rtl/wrr_arbiter_if.sv | 41 ++++
 rtl/wrr_arbiter_counter_base.sv | 33 +++
 rtl/wrr_arbiter.sv | 124 ++++++++++++
 tb/tb_wrr_arbiter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/wrr_arbiter_pkg.sv
// Shared types and default sizes for the weighted round-robin arbiter.
// Optional feature macro: WRR_ARBITER_LOCK_EN (adds a burst-extending lock input).
package wrr_arbiter_pkg;

  typedef enum logic [0:0] {ST_IDLE, ST_GRANT} wrr_state_t;

  localparam int DEFAULT_NUM_REQ      = 4;
  localparam int DEFAULT_WEIGHT_WIDTH = 3;

endpackage

// File: rtl/wrr_arbiter_if.sv
// Requester-side bundle of the weighted round-robin arbiter.
// The master modport is the requester/resource side, slave is the arbiter.
// Optional feature macro: WRR_ARBITER_LOCK_EN (adds i__lock).
interface wrr_arbiter_if
  import wrr_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = DEFAULT_NUM_REQ,
  parameter int WEIGHT_WIDTH = DEFAULT_WEIGHT_WIDTH
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ*WEIGHT_WIDTH-1:0] i__weight;
  logic [NUM_REQ-1:0]              i__req;
  logic                            i__ack;
  logic                            o__valid;
  logic [NUM_REQ-1:0]              o__grant;
  logic [ID_WIDTH-1:0]             o__grant_id;
  logic [WEIGHT_WIDTH-1:0]         o__burst_count;
`ifdef WRR_ARBITER_LOCK_EN
  logic                            i__lock;

  modport master (
    output i__weight, i__req, i__ack, i__lock,
    input  o__valid, o__grant, o__grant_id, o__burst_count
  );
  modport slave (
    input  i__weight, i__req, i__ack, i__lock,
    output o__valid, o__grant, o__grant_id, o__burst_count
  );
`else
  modport master (
    output i__weight, i__req, i__ack,
    input  o__valid, o__grant, o__grant_id, o__burst_count
  );
  modport slave (
    input  i__weight, i__req, i__ack,
    output o__valid, o__grant, o__grant_id, o__burst_count
  );
`endif

endinterface

// File: rtl/wrr_arbiter_counter_base.sv
// Generic wrapping up-counter used to count acks within a burst.
// Counts 0..i__max_count then wraps to 0 on the next increment.
module counter_base #(
  parameter int                     COUNT_WIDTH = 3,
  parameter logic [COUNT_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i__inc,
  input  logic [COUNT_WIDTH-1:0] i__max_count,
  output logic [COUNT_WIDTH-1:0] o__count,
  output logic                   o__at_max
);

  logic [COUNT_WIDTH-1:0] count_reg;

  // Increment on request, wrapping to zero once the maximum has been reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= INIT_VALUE;
    end else if (i__inc) begin
      if (count_reg == i__max_count) begin
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign o__count  = count_reg;
  assign o__at_max = (count_reg == i__max_count);

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: the grantee keeps the resource for weight+1
// accepted transfers, then the grant rotates to the next requester.
// Optional feature macro: WRR_ARBITER_LOCK_EN (i__lock suppresses burst end).
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = DEFAULT_NUM_REQ,
  parameter int WEIGHT_WIDTH = DEFAULT_WEIGHT_WIDTH
) (
  input logic           clk,
  input logic           reset,
  wrr_arbiter_if.slave  bus
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  wrr_state_t              state_reg;
  logic [ID_WIDTH-1:0]     ptr_reg;
  logic                    valid_reg;
  logic [NUM_REQ-1:0]      grant_reg;
  logic [ID_WIDTH-1:0]     id_reg;
  logic [WEIGHT_WIDTH-1:0] weight_reg;

  logic [WEIGHT_WIDTH-1:0] weight_field [NUM_REQ];
  logic [2*NUM_REQ-1:0]    req_dbl;
  logic [NUM_REQ-1:0]      req_rot;
  logic [ID_WIDTH-1:0]     pick_offset;
  logic [ID_WIDTH:0]       pick_sum;
  logic [ID_WIDTH-1:0]     pick_id;
  logic [NUM_REQ-1:0]      pick_onehot;
  logic [ID_WIDTH-1:0]     next_ptr;
  logic                    lock_active;
  logic                    ack_in_burst;
  logic                    burst_end;
  logic                    abandon;
  logic                    counter_rst;
  logic                    count_at_max;
  logic [WEIGHT_WIDTH-1:0] burst_count;

  // Split the packed weight bus into one field per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_weight
    assign weight_field[gi] = bus.i__weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  end

`ifdef WRR_ARBITER_LOCK_EN
  assign lock_active = bus.i__lock;
`else
  assign lock_active = 1'b0;
`endif

  // An ack that lands on the last quantum slot ends the burst unless locked;
  // a dropped request without an ack abandons it (lock never blocks that).
  assign ack_in_burst = bus.i__ack & valid_reg;
  assign burst_end    = ack_in_burst & count_at_max & ~lock_active;
  assign abandon      = valid_reg & ~bus.i__ack & ~bus.i__req[id_reg];
  assign counter_rst  = reset | abandon;
  assign next_ptr     = (id_reg == ID_WIDTH'(NUM_REQ-1)) ? '0 : id_reg + 1'b1;

  // Rotate requests so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    req_dbl     = {bus.i__req, bus.i__req} >> ptr_reg;
    req_rot     = req_dbl[NUM_REQ-1:0];
    pick_offset = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) pick_offset = ID_WIDTH'(i);
    end
    pick_sum = {1'b0, ptr_reg} + {1'b0, pick_offset};
    if (pick_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
      pick_sum = pick_sum - (ID_WIDTH+1)'(NUM_REQ);
    end
    pick_id     = pick_sum[ID_WIDTH-1:0];
    pick_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
  end

  // Grant FSM: issue a grant from IDLE, return to IDLE on burst end or abandon.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= '0;
      valid_reg  <= 1'b0;
      grant_reg  <= '0;
      id_reg     <= '0;
      weight_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|bus.i__req) begin
            state_reg  <= ST_GRANT;
            valid_reg  <= 1'b1;
            grant_reg  <= pick_onehot;
            id_reg     <= pick_id;
            weight_reg <= weight_field[pick_id];
          end
        end
        ST_GRANT: begin
          if (burst_end || abandon) begin
            state_reg <= ST_IDLE;
            valid_reg <= 1'b0;
            grant_reg <= '0;
            ptr_reg   <= next_ptr;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  counter_base #(
    .COUNT_WIDTH (WEIGHT_WIDTH),
    .INIT_VALUE  ('0)
  ) u_burst_counter (
    .clk          (clk),
    .reset        (counter_rst),
    .i__inc       (ack_in_burst),
    .i__max_count (weight_reg),
    .o__count     (burst_count),
    .o__at_max    (count_at_max)
  );

  assign bus.o__valid       = valid_reg;
  assign bus.o__grant       = grant_reg;
  assign bus.o__grant_id    = id_reg;
  assign bus.o__burst_count = burst_count;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Testbench for wrr_arbiter (NUM_REQ=4, WEIGHT_WIDTH=3): directed scenarios
// followed by random traffic, compared every cycle against a behavioural model.
// Lock scenarios are exercised when WRR_ARBITER_LOCK_EN is defined.
module tb_wrr_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural model: who holds the grant, acks taken, quantum, search start.
  int m_valid = 0;
  int m_id    = 0;
  int m_cnt   = 0;
  int m_wt    = 0;
  int m_ptr   = 0;

  logic [3:0]  cur_req;
  logic [11:0] cur_wt;

  wrr_arbiter_if #(.NUM_REQ(4), .WEIGHT_WIDTH(3)) bus ();

  wrr_arbiter #(.NUM_REQ(4), .WEIGHT_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the reference behaviour, from the rules rather than any encoding.
  task automatic model_step(input logic [3:0] req, input logic [11:0] wt,
                            input logic ack, input logic lock, input logic rst);
    bit found;
    if (rst) begin
      m_valid = 0; m_id = 0; m_cnt = 0; m_wt = 0; m_ptr = 0;
    end else if (m_valid == 0) begin
      if (req != 4'd0) begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = (m_ptr + k) % 4;
          if (!found && req[idx]) begin
            m_id  = idx;
            found = 1;
          end
        end
        m_wt    = int'((wt >> (3 * m_id)) & 12'd7);
        m_cnt   = 0;
        m_valid = 1;
      end
    end else if (ack) begin
      if (m_cnt == m_wt) begin
        m_cnt = 0;
        if (!lock) begin
          m_valid = 0;
          m_ptr   = (m_id + 1) % 4;
        end
      end else begin
        m_cnt++;
      end
    end else if (!req[m_id]) begin
      m_valid = 0;
      m_cnt   = 0;
      m_ptr   = (m_id + 1) % 4;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic [3:0] req, input logic [11:0] wt,
                      input logic ack, input logic lock, input logic rst);
    logic [31:0] exp_grant;
    reset         = rst;
    bus.i__req    = req;
    bus.i__weight = wt;
    bus.i__ack    = ack;
`ifdef WRR_ARBITER_LOCK_EN
    bus.i__lock   = lock;
`endif
    model_step(req, wt, ack, lock, rst);
    @(posedge clk);
    #1;
    exp_grant = (m_valid != 0) ? (32'd1 << m_id) : 32'd0;
    check("valid", 32'(bus.o__valid), 32'(m_valid));
    check("grant", 32'(bus.o__grant), exp_grant);
    if (m_valid != 0 || rst) check("grant_id", 32'(bus.o__grant_id), 32'(m_id));
    check("burst_count", 32'(bus.o__burst_count), 32'(m_cnt));
  endtask

  initial begin
    reset         = 1'b1;
    bus.i__req    = '0;
    bus.i__weight = '0;
    bus.i__ack    = 1'b0;
`ifdef WRR_ARBITER_LOCK_EN
    bus.i__lock   = 1'b0;
`endif

    // Reset held two cycles with all requests pending, then release.
    step(4'b1111, 12'h000, 1'b0, 1'b0, 1'b1);
    step(4'b1111, 12'h000, 1'b0, 1'b0, 1'b1);
    step(4'b1111, 12'h000, 1'b0, 1'b0, 1'b0);
    check("reset_first_grant_id0", 32'(bus.o__grant), 32'h1);
    step(4'b1111, 12'h000, 1'b1, 1'b0, 1'b0);

    // Single requester 2 with weight 2: three acks, then search resumes at id 3.
    step(4'b0000, 12'h000, 1'b0, 1'b0, 1'b1);
    step(4'b0100, 12'h080, 1'b0, 1'b0, 1'b0);
    check("single_grant_0100", 32'(bus.o__grant), 32'h4);
    for (int i = 0; i < 3; i++) step(4'b0100, 12'h080, 1'b1, 1'b0, 1'b0);
    check("single_valid_after_3_acks", 32'(bus.o__valid), 32'h0);
    step(4'b1111, 12'h080, 1'b0, 1'b0, 1'b0);
    check("single_next_id3", 32'(bus.o__grant_id), 32'd3);

    // Plain round robin: all weights zero, ack whenever a grant is up.
    step(4'b0000, 12'h000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(4'b1111, 12'h000, m_valid != 0, 1'b0, 1'b0);

    // Weighted: id 0 gets 2 acks, id 1 gets 4 acks, repeating.
    step(4'b0000, 12'h000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) step(4'b0011, 12'h019, m_valid != 0, 1'b0, 1'b0);

    // Abandon: id 1 with weight 5 drops its request after one ack.
    step(4'b0000, 12'h000, 1'b0, 1'b0, 1'b1);
    step(4'b0110, 12'h028, 1'b0, 1'b0, 1'b0);
    step(4'b0110, 12'h028, 1'b1, 1'b0, 1'b0);
    step(4'b0100, 12'h028, 1'b0, 1'b0, 1'b0);
    check("abandon_count_cleared", 32'(bus.o__burst_count), 32'd0);
    step(4'b0100, 12'h028, 1'b0, 1'b0, 1'b0);
    check("abandon_next_id2", 32'(bus.o__grant_id), 32'd2);

`ifdef WRR_ARBITER_LOCK_EN
    // Lock: weight 0 grant survives locked acks, ends on an unlocked ack.
    step(4'b0000, 12'h000, 1'b0, 1'b0, 1'b1);
    step(4'b0001, 12'h000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0001, 12'h000, 1'b1, 1'b1, 1'b0);
    check("lock_held", 32'(bus.o__valid), 32'h1);
    step(4'b0001, 12'h000, 1'b1, 1'b0, 1'b0);
    check("lock_released", 32'(bus.o__valid), 32'h0);
    step(4'b0001, 12'h000, 1'b0, 1'b1, 1'b0);
    step(4'b0001, 12'h000, 1'b1, 1'b1, 1'b1);
    check("lock_reset_mid_burst", 32'(bus.o__valid), 32'h0);
`endif

    // Random traffic including mid-burst resets, abandons and weight changes.
    step(4'b0000, 12'h000, 1'b0, 1'b0, 1'b1);
    cur_req = 4'($urandom_range(0, 15));
    cur_wt  = 12'($urandom);
    for (int i = 0; i < 600; i++) begin
      logic rnd_rst, rnd_ack, rnd_lock;
      if ($urandom_range(0, 4) == 0) cur_req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) cur_wt = 12'($urandom);
      rnd_rst = ($urandom_range(0, 59) == 0);
      rnd_ack = ($urandom_range(0, 2) != 0);
`ifdef WRR_ARBITER_LOCK_EN
      rnd_lock = ($urandom_range(0, 3) == 0);
`else
      rnd_lock = 1'b0;
`endif
      step(cur_req, cur_wt, rnd_ack, rnd_lock, rnd_rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
